uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter (tx module: tx_ready/tx_data in, tx_rd out) among
//  NUM_REQ line-oriented message sources (command response, ERROR text, status reports).
//  Arbitration is per line: a grant holds until the granted source's EOL (0x0a) byte is
//  accepted, so lines never interleave. Round-robin across lines.
//  A stalled source is aborted after TIMEOUT idle cycles; the arbiter closes the line itself.
// PARAMETERS
//  NUM_REQ   3        number of requesters (2..8)
//  TIMEOUT   1000     max consecutive cycles a granted source may hold req_vld low
//  CNT_W     10       timeout counter width, must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk        in   1          system clock, all logic on rising edge
//  rst        in   1          asynchronous reset, ACTIVE-LOW (low = reset)
//  req_vld    in   NUM_REQ    per-source: req_data byte is valid
//  req_data   in   8*NUM_REQ  per-source byte, source i at [8*i+7:8*i]
//  req_rd     out  NUM_REQ    per-source pop strobe: byte taken this cycle
//  grant      out  NUM_REQ    one-hot current owner, 0 when idle
//  abort      out  NUM_REQ    1-cycle pulse: source i's line was cut by timeout
//  busy       out  1          high in S_XFER or S_ABORT
//  tx_ready   out  1          byte valid toward tx module
//  tx_data    out  8          byte toward tx module
//  tx_rd      in   1          tx accepted tx_data this cycle (only meaningful with tx_ready)
// BEHAVIOUR
//  Reset (rst low, async): state=S_IDLE, grant=0, last=NUM_REQ-1, cnt=0; all outputs 0.
//  FSM (registered state, 2-bit):
//   S_IDLE : tx_ready=0, tx_data=0, req_rd=0. If any req_vld: grant<=rr_pick(req_vld,last),
//            cnt<=0, ->S_XFER (1 cycle arbitration latency; req_vld sampled this cycle only).
//   S_XFER : g = owner. tx_ready=req_vld[g], tx_data=req_data[g] (combinational pass-through),
//            req_rd[g]=tx_rd & req_vld[g], other req_rd=0.
//            Accepted byte (tx_rd&req_vld[g]) == 0x0a -> last<=g, grant<=0, ->S_IDLE.
//            req_vld[g]=0: cnt<=cnt+1; cnt==TIMEOUT-1 -> ->S_ABORT. req_vld[g]=1: cnt<=0.
//            Backpressure (req_vld high, tx_rd low) never counts toward timeout.
//   S_ABORT: tx_ready=1, tx_data=0x0a, req_rd=0. On tx_rd: abort[g]=1 for that cycle,
//            last<=g, grant<=0, ->S_IDLE.
//  Round-robin: search starts at last+1, wraps modulo NUM_REQ; owner of previous line has lowest
//   priority. Sole requester is re-granted immediately (no fairness bubble beyond S_IDLE cycle).
//  Back-to-back lines: at least one S_IDLE cycle between EOL accept and next first byte.
//  Source dropping req_vld mid-line: legal, link waits (timeout applies). Source must not
//   change req_data while req_vld high and req_rd low.
//  tx_rd while tx_ready=0: ignored. Requests from non-owners during S_XFER/S_ABORT: held off,
//   no req_rd, arbitrated at next S_IDLE.
//  Zero-length line (first byte is 0x0a): forwarded, releases grant normally.
//  Reset mid-line: immediate return to S_IDLE; partial line on the wire is not repaired.
//  cnt saturates nowhere: it leaves S_XFER at TIMEOUT-1, so no overflow.
// STRUCTURE
//  uart_pkg: EOL_BYTE=8'h0a, state encodings S_IDLE/S_XFER/S_ABORT, shared with rx/tx top FSM.
//  Sub-module rr_pick (combinational, params NUM_REQ): inputs req vector + last index,
//   outputs one-hot winner + index. Everything else (FSM, cnt, muxes) in this module.
// TESTING
//  1 Reset: hold rst=0, drive req_vld=3'b111 -> all outputs 0; release -> grant=001 next cycle.
//  2 Single line: src0 sends "rb\n" (72 62 0a), tx_rd every 2nd cycle -> tx_data 72,62,0a in
//    order, 3 req_rd[0] pulses, grant 001->000 after 0x0a accept, busy low next cycle.
//  3 Contention: src0,1,2 all hold 2-byte lines "A\n" -> line order src0,src1,src2,src0;
//    no byte of one line between bytes of another.
//  4 Timeout: TIMEOUT=8, src1 sends 0x45 then drops req_vld -> 8 idle cycles later tx_data=0a,
//    tx_ready=1; on tx_rd abort=010 one cycle, grant=0.
//  5 Backpressure: src2 holds 0x31 valid, tx_rd low 50 cycles, TIMEOUT=8 -> no abort, byte
//    delivered once tx_rd rises.
//  6 Async reset mid-line (after 2 of 5 bytes) -> state S_IDLE same cycle, tx_ready=0, grant=0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART constants: EOL byte and the top FSM state encodings.
// No ports; imported by the arbiter, its interface and the rx/tx tops.
package uart_tx_arbiter_pkg;

  localparam logic [7:0] EOL_BYTE = 8'h0a;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Source/transmitter bus of the line arbiter.
// master: sources + tx (drive req_vld/req_data/tx_rd); slave: arbiter.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
);

  logic [NUM_REQ-1:0]   req_vld;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_rd;
  logic                 tx_ready;
  logic [7:0]           tx_data;
  logic                 tx_rd;

  modport master (
    output req_vld,
    output req_data,
    output tx_rd,
    input  req_rd,
    input  tx_ready,
    input  tx_data
  );

  modport slave (
    input  req_vld,
    input  req_data,
    input  tx_rd,
    output req_rd,
    output tx_ready,
    output tx_data
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after 'last'.
// Ports: req, last in; win (one-hot), win_idx, any out.
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] win,
  output logic [IW-1:0]      win_idx,
  output logic               any
);

  int j;

  // Search order last+1 .. last+NUM_REQ, so 'last' is visited last.
  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last) + k) % NUM_REQ;
      if (!any && req[j]) begin
        any     = 1'b1;
        win[j]  = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Line-granular round-robin arbiter sharing one UART tx among sources.
// Ports: clk, rst (async, active low), bus (slave), grant, abort, busy.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] abort,
  output logic               busy
);

  localparam int IW = idx_w(NUM_REQ);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        own_q, own_d;
  logic [IW-1:0]        last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  logic [7:0]           req_bytes [NUM_REQ];
  logic                 own_vld;
  logic [7:0]           own_byte;
  logic                 accept;

  logic [NUM_REQ-1:0]   req_rd_c;
  logic [NUM_REQ-1:0]   abort_c;
  logic                 tx_ready_c;
  logic [7:0]           tx_data_c;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_bytes[i] = bus.req_data[8*i +: 8];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req     (bus.req_vld),
    .last    (last_q),
    .win     (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  assign own_vld  = bus.req_vld[own_q];
  assign own_byte = req_bytes[own_q];
  assign accept   = own_vld & bus.tx_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      own_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      own_q   <= own_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    own_d      = own_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    tx_ready_c = 1'b0;
    tx_data_c  = 8'h00;
    req_rd_c   = '0;
    abort_c    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          grant_d = pick_oh;
          own_d   = pick_idx;
          cnt_d   = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        tx_ready_c = own_vld;
        tx_data_c  = own_byte;
        req_rd_c   = accept ? grant_q : '0;
        if (accept && own_byte == EOL_BYTE) begin
          last_d  = own_q;
          grant_d = '0;
          state_d = S_IDLE;
        end else if (!own_vld) begin
          // Only a silent source ages; tx backpressure never does.
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = S_ABORT;
          end
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      S_ABORT: begin
        // Close the cut line on the wire with our own EOL.
        tx_ready_c = 1'b1;
        tx_data_c  = EOL_BYTE;
        if (bus.tx_rd) begin
          abort_c = grant_q;
          last_d  = own_q;
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign bus.tx_ready = tx_ready_c;
  assign bus.tx_data  = tx_data_c;
  assign bus.req_rd   = req_rd_c;
  assign abort        = abort_c;
  assign grant        = grant_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random line traffic
// checked against a line-level round-robin model.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] grant;
  logic [N-1:0] abort;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_arbiter_if #(.NUM_REQ(N)) intf ();

  uart_tx_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (TO),
    .CNT_W   (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (intf.slave),
    .grant (grant),
    .abort (abort),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] src_q [N][$];
  logic [7:0] exp_q [N][$];
  int         gap [N];
  int         line_order [$];
  bit         m_idle;
  int         m_owner;
  int         m_last;

  function automatic int rr_model(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic int exp_left();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += exp_q[i].size();
    return s;
  endfunction

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && gap[i] == 0) begin
        intf.req_vld[i]         = 1'b1;
        intf.req_data[8*i +: 8] = src_q[i][0];
      end else begin
        intf.req_vld[i]         = 1'b0;
        intf.req_data[8*i +: 8] = 8'h00;
      end
    end
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    intf.req_vld  = '0;
    intf.req_data = '0;
    intf.tx_rd    = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      gap[i] = 0;
    end
    line_order.delete();
    m_idle  = 1'b1;
    m_last  = N - 1;
    m_owner = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input int s, input int len);
    logic [7:0] b;
    for (int k = 0; k < len - 1; k++) begin
      b = 8'($urandom_range(0, 254));
      if (b >= EOL_BYTE) b = b + 8'd1;
      src_q[s].push_back(b);
      exp_q[s].push_back(b);
    end
    src_q[s].push_back(EOL_BYTE);
    exp_q[s].push_back(EOL_BYTE);
  endtask

  task automatic run_traffic(input int max_cyc, input bit rnd);
    int         cyc;
    int         p;
    logic [7:0] b;
    logic [N-1:0] tk;
    logic [N-1:0] ereq;
    logic [N-1:0] egnt;
    cyc = 0;
    drive_src();
    intf.tx_rd = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (exp_left() > 0 && cyc < max_cyc) begin
      @(negedge clk);
      if (m_idle) begin
        n_tests++;
        if (grant !== '0 || busy !== 1'b0 || intf.tx_ready !== 1'b0 ||
            intf.req_rd !== '0) begin
          n_fail++;
          $display("FAIL idle_outputs: grant=%b busy=%b tx_ready=%b req_rd=%b, need all 0",
                   grant, busy, intf.tx_ready, intf.req_rd);
        end
        if (|intf.req_vld) begin
          p = rr_model(intf.req_vld, m_last);
          m_owner = p;
          m_idle  = 1'b0;
          line_order.push_back(p);
        end
      end else begin
        ereq = '0;
        egnt = '0;
        egnt[m_owner] = 1'b1;
        if (intf.tx_rd && intf.req_vld[m_owner]) ereq[m_owner] = 1'b1;
        n_tests++;
        if (grant !== egnt || intf.req_rd !== ereq || abort !== '0 ||
            intf.tx_ready !== intf.req_vld[m_owner]) begin
          n_fail++;
          $display("FAIL xfer_ctrl: grant=%b req_rd=%b abort=%b tx_ready=%b, need grant=%b req_rd=%b abort=0 tx_ready=%b",
                   grant, intf.req_rd, abort, intf.tx_ready, egnt, ereq,
                   intf.req_vld[m_owner]);
        end
        if (|ereq) begin
          n_tests++;
          if (exp_q[m_owner].size() == 0) begin
            n_fail++;
            $display("FAIL xfer_extra: src%0d byte %h taken, need none left",
                     m_owner, intf.tx_data);
          end else begin
            b = exp_q[m_owner].pop_front();
            if (intf.tx_data !== b) begin
              n_fail++;
              $display("FAIL xfer_data: src%0d tx_data=%h, need %h",
                       m_owner, intf.tx_data, b);
            end
            if (b == EOL_BYTE) begin
              m_last = m_owner;
              m_idle = 1'b1;
            end
          end
        end
      end
      tk = intf.req_rd;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (tk[i] && src_q[i].size() > 0) begin
          void'(src_q[i].pop_front());
          gap[i] = (rnd && $urandom_range(0, 3) == 0) ?
                   int'($urandom_range(1, 3)) : 0;
        end else if (gap[i] > 0) begin
          gap[i]--;
        end
      end
      drive_src();
      intf.tx_rd = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc++;
    end
    n_tests++;
    if (exp_left() != 0) begin
      n_fail++;
      $display("FAIL traffic_timeout: %0d bytes left after %0d cycles, need 0",
               exp_left(), cyc);
    end
    intf.tx_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    intf.req_vld  = 3'b111;
    intf.req_data = 24'($urandom);
    intf.tx_rd    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (grant !== '0 || abort !== '0 || busy !== 1'b0 ||
        intf.tx_ready !== 1'b0 || intf.tx_data !== 8'h00 ||
        intf.req_rd !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b abort=%b busy=%b tx_ready=%b tx_data=%h req_rd=%b, need all 0",
               grant, abort, busy, intf.tx_ready, intf.tx_data, intf.req_rd);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (grant !== 3'b001 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: grant=%b busy=%b, need 001 1", grant, busy);
    end
  endtask

  task automatic test_single_line();
    logic [7:0] ln [3];
    int  pos, nrd, got;
    bit  done, tk;
    ln = '{8'h72, 8'h62, 8'h0a};
    do_reset();
    pos = 0; nrd = 0; got = 0; done = 1'b0;
    intf.tx_rd = 1'b0;
    intf.req_vld[0] = 1'b1;
    intf.req_data[7:0] = ln[0];
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (intf.req_rd[0]) nrd++;
      if (intf.tx_ready && intf.tx_rd && got < 3) begin
        n_tests++;
        if (intf.tx_data !== ln[got]) begin
          n_fail++;
          $display("FAIL single_data: byte %0d tx_data=%h, need %h", got, intf.tx_data, ln[got]);
        end
        if (intf.tx_data === EOL_BYTE) begin
          done = 1'b1;
          n_tests++;
          if (grant !== 3'b001) begin
            n_fail++;
            $display("FAIL single_grant_eol: grant=%b, need 001", grant);
          end
        end
        got++;
      end
      tk = intf.req_rd[0];
      @(posedge clk);
      #1;
      if (tk) pos++;
      intf.req_vld[0] = (pos < 3);
      intf.req_data[7:0] = (pos < 3) ? ln[pos] : 8'h00;
      intf.tx_rd = ~intf.tx_rd;
    end
    n_tests++;
    if (!done || nrd != 3) begin
      n_fail++;
      $display("FAIL single_count: eol_seen=%0d req_rd_pulses=%0d, need 1 3", done, nrd);
    end
    n_tests++;
    if (grant !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: grant=%b busy=%b, need 000 0", grant, busy);
    end
  endtask

  task automatic test_contention();
    int ord [6];
    ord = '{0, 1, 2, 0, 1, 2};
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) begin
        src_q[i].push_back(8'h41); exp_q[i].push_back(8'h41);
        src_q[i].push_back(EOL_BYTE); exp_q[i].push_back(EOL_BYTE);
      end
    run_traffic(200, 1'b0);
    n_tests++;
    if (line_order.size() != 6) begin
      n_fail++;
      $display("FAIL contention_lines: %0d lines, need 6", line_order.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_tests++;
        if (line_order[k] != ord[k]) begin
          n_fail++;
          $display("FAIL contention_order: line %0d owner=%0d, need %0d",
                   k, line_order[k], ord[k]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    intf.req_vld  = 3'b010;
    intf.req_data = {8'h00, 8'h45, 8'h00};
    intf.tx_rd    = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if (intf.req_rd !== 3'b010 || intf.tx_data !== 8'h45) begin
      n_fail++;
      $display("FAIL timeout_first: req_rd=%b tx_data=%h, need 010 45", intf.req_rd, intf.tx_data);
    end
    @(posedge clk);
    #1;
    intf.req_vld = '0;
    intf.tx_rd   = 1'b0;
    bad = 0;
    repeat (TO) begin
      @(negedge clk);
      if (intf.tx_ready !== 1'b0 || abort !== '0 || grant !== 3'b010) bad++;
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL timeout_wait: %0d bad wait cycles, need 0", bad);
    end
    @(negedge clk);
    n_tests++;
    if (intf.tx_ready !== 1'b1 || intf.tx_data !== EOL_BYTE || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_eol: tx_ready=%b tx_data=%h busy=%b, need 1 0a 1",
               intf.tx_ready, intf.tx_data, busy);
    end
    intf.tx_rd = 1'b1;
    #1;
    n_tests++;
    if (abort !== 3'b010 || intf.req_rd !== '0) begin
      n_fail++;
      $display("FAIL timeout_abort: abort=%b req_rd=%b, need 010 000", abort, intf.req_rd);
    end
    @(posedge clk);
    #1;
    intf.tx_rd = 1'b0;
    n_tests++;
    if (abort !== '0 || grant !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_release: abort=%b grant=%b busy=%b, need 000 000 0", abort, grant, busy);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    intf.req_vld  = 3'b100;
    intf.req_data = {8'h31, 8'h00, 8'h00};
    intf.tx_rd    = 1'b0;
    @(posedge clk);
    #1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (abort !== '0 || intf.tx_ready !== 1'b1 || intf.tx_data !== 8'h31 ||
          grant !== 3'b100 || intf.req_rd !== '0) bad++;
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d bad stall cycles, need 0", bad);
    end
    intf.tx_rd = 1'b1;
    @(negedge clk);
    n_tests++;
    if (intf.req_rd !== 3'b100 || intf.tx_data !== 8'h31) begin
      n_fail++;
      $display("FAIL bp_deliver: req_rd=%b tx_data=%h, need 100 31", intf.req_rd, intf.tx_data);
    end
    @(posedge clk);
    #1;
    intf.req_data = {EOL_BYTE, 8'h00, 8'h00};
    @(negedge clk);
    n_tests++;
    if (intf.req_rd !== 3'b100 || intf.tx_data !== EOL_BYTE) begin
      n_fail++;
      $display("FAIL bp_eol: req_rd=%b tx_data=%h, need 100 0a", intf.req_rd, intf.tx_data);
    end
    @(posedge clk);
    #1;
    intf.req_vld = '0;
    intf.tx_rd   = 1'b0;
    n_tests++;
    if (grant !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: grant=%b busy=%b, need 000 0", grant, busy);
    end
  endtask

  task automatic test_reset_midline();
    int  taken;
    bit  tk;
    do_reset();
    src_q[0] = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h0a};
    intf.tx_rd = 1'b1;
    drive_src();
    taken = 0;
    for (int c = 0; c < 20 && taken < 2; c++) begin
      @(negedge clk);
      tk = intf.req_rd[0];
      if (tk) taken++;
      @(posedge clk);
      #1;
      if (tk) void'(src_q[0].pop_front());
      drive_src();
    end
    n_tests++;
    if (taken != 2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midline_pre: taken=%0d busy=%b, need 2 1", taken, busy);
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (grant !== '0 || intf.tx_ready !== 1'b0 || busy !== 1'b0 ||
        intf.req_rd !== '0) begin
      n_fail++;
      $display("FAIL midline_reset: grant=%b tx_ready=%b busy=%b req_rd=%b, need all 0",
               grant, intf.tx_ready, busy, intf.req_rd);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        int nl;
        nl = int'($urandom_range(1, 4));
        for (int l = 0; l < nl; l++) push_line(i, int'($urandom_range(1, 6)));
      end
      run_traffic(4000, 1'b1);
    end
  endtask

  initial begin
    rst           = 1'b0;
    intf.req_vld  = '0;
    intf.req_data = '0;
    intf.tx_rd    = 1'b0;
    test_reset();
    test_single_line();
    test_contention();
    test_timeout();
    test_backpressure();
    test_reset_midline();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
